// File: rtl/ycbcr_class_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ycbcr_class_pkg
//  Brief    : Shared types and constants for the YCbCr multi-class
//             threshold classifier: threshold record layout, cfg_wdata
//             field offsets, default class count and a clog2 helper.
//  Revision : 1.0  initial release
// ============================================================================
package ycbcr_class_pkg;

    // Component width the threshold record is built around.
    localparam int c_cw            = 8;
    localparam int c_wdata_w       = 6*c_cw + 1;

    // cfg_wdata layout {en,YL,YH,CBL,CBH,CRL,CRH}, enable in the MSB.
    localparam int c_crh_lsb       = 0;
    localparam int c_crl_lsb       = 1*c_cw;
    localparam int c_cbh_lsb       = 2*c_cw;
    localparam int c_cbl_lsb       = 3*c_cw;
    localparam int c_yh_lsb        = 4*c_cw;
    localparam int c_yl_lsb        = 5*c_cw;
    localparam int c_en_bit        = 6*c_cw;

    // Default number of classes; the class code equal to the class count
    // means "no class matched".
    localparam int c_num_class_def = 12;
    localparam int NO_CLASS        = c_num_class_def;

    typedef struct packed {
        logic            en;
        logic [c_cw-1:0] yl;
        logic [c_cw-1:0] yh;
        logic [c_cw-1:0] cbl;
        logic [c_cw-1:0] cbh;
        logic [c_cw-1:0] crl;
        logic [c_cw-1:0] crh;
    } thresh_t;

    // Ceiling log2 for elaboration-time width calculations.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Unpacks a configuration word into a threshold record.
    function automatic thresh_t unpack_thresh(input logic [c_wdata_w-1:0] w);
        thresh_t t;
        t.en  = w[c_en_bit];
        t.yl  = w[c_yl_lsb  +: c_cw];
        t.yh  = w[c_yh_lsb  +: c_cw];
        t.cbl = w[c_cbl_lsb +: c_cw];
        t.cbh = w[c_cbh_lsb +: c_cw];
        t.crl = w[c_crl_lsb +: c_cw];
        t.crh = w[c_crh_lsb +: c_cw];
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ycbcr_range_cmp.sv
`default_nettype none
// ============================================================================
//  Module   : ycbcr_range_cmp
//  Brief    : Combinational 3-channel inclusive window test of one pixel
//             against one threshold record. A disabled record, or any
//             channel with low bound above high bound, never hits.
//  Revision : 1.0  initial release
// ============================================================================
module ycbcr_range_cmp
    import ycbcr_class_pkg::*;
(
    input  thresh_t         i_thr,
    input  logic [c_cw-1:0] i_y,
    input  logic [c_cw-1:0] i_cb,
    input  logic [c_cw-1:0] i_cr,
    output logic            o_hit
);

    logic w_y_in;
    logic w_cb_in;
    logic w_cr_in;

    assign w_y_in  = (i_y  >= i_thr.yl)  && (i_y  <= i_thr.yh);
    assign w_cb_in = (i_cb >= i_thr.cbl) && (i_cb <= i_thr.cbh);
    assign w_cr_in = (i_cr >= i_thr.crl) && (i_cr <= i_thr.crh);

    assign o_hit = i_thr.en && w_y_in && w_cb_in && w_cr_in;

endmodule
`default_nettype wire

// File: rtl/ycbcr_class_thresh.sv
`default_nettype none
// ============================================================================
//  Module   : ycbcr_class_thresh
//  Brief    : Multi-class YCbCr window classifier. Double-buffered
//             threshold table (shadow written any time, active loaded at
//             frame start), 2-cycle pipeline producing raw hit mask and
//             priority class, aligned RGB/sync pass-through, and optional
//             per-class winner counters enabled by macro CLASS_COUNT_EN.
//             CW must match the package component width.
//  Revision : 1.0  initial release
// ============================================================================
module ycbcr_class_thresh
    import ycbcr_class_pkg::*;
#(
    parameter int CW        = c_cw,
    parameter int DW        = 24,
    parameter int NUM_CLASS = c_num_class_def,
    parameter int CLW       = clog2(NUM_CLASS + 1),
    parameter int CNTW      = 20
)(
    input  logic                      pixelclk,
    input  logic                      reset,
    input  logic [3*CW-1:0]           i_ycbcr,
    input  logic [DW-1:0]             i_rgb,
    input  logic                      i_hsync,
    input  logic                      i_vsync,
    input  logic                      i_de,
    input  logic                      cfg_we,
    input  logic [CLW-1:0]            cfg_class,
    input  logic [6*CW:0]             cfg_wdata,
    output logic [CLW-1:0]            o_class,
    output logic [NUM_CLASS-1:0]      o_hit,
    output logic [DW-1:0]             o_rgb,
    output logic                      o_hsync,
    output logic                      o_vsync,
    output logic                      o_de,
    output logic [NUM_CLASS*CNTW-1:0] o_cnt,
    output logic                      o_cnt_vld
);

    localparam logic [CLW-1:0] c_no_class  = CLW'(NUM_CLASS);

    thresh_t              r_shadow [NUM_CLASS];
    thresh_t              r_active [NUM_CLASS];
    logic                 r_vs_in_d;
    logic                 w_frame_start;

    logic [CW-1:0]        w_y;
    logic [CW-1:0]        w_cb;
    logic [CW-1:0]        w_cr;
    logic [NUM_CLASS-1:0] w_hit;

    logic [NUM_CLASS-1:0] r_hit1;
    logic [CLW-1:0]       w_class1;
    logic [DW-1:0]        r_rgb1;
    logic                 r_hs1;
    logic                 r_vs1;
    logic                 r_de1;

    logic                 r_ovs_d;
    logic                 w_out_frame;

    assign w_y  = i_ycbcr[3*CW-1 -: CW];
    assign w_cb = i_ycbcr[2*CW-1 -: CW];
    assign w_cr = i_ycbcr[CW-1   -: CW];

    assign w_frame_start = i_vsync & ~r_vs_in_d;

    // Threshold tables: the copy reads the shadow before any same-cycle
    // write lands, so a write on the frame-start cycle waits a frame.
    always_ff @(posedge pixelclk) begin
        if (reset) begin
            r_vs_in_d <= 1'b0;
            for (int k = 0; k < NUM_CLASS; k++) begin
                r_shadow[k] <= '0;
                r_active[k] <= '0;
            end
        end else begin
            r_vs_in_d <= i_vsync;
            if (w_frame_start) begin
                for (int k = 0; k < NUM_CLASS; k++) begin
                    r_active[k] <= r_shadow[k];
                end
            end
            if (cfg_we && (cfg_class < c_no_class)) begin
                r_shadow[cfg_class] <= unpack_thresh(cfg_wdata);
            end
        end
    end

    generate
        for (genvar k = 0; k < NUM_CLASS; k++) begin : g_cmp
            ycbcr_range_cmp u_cmp (
                .i_thr (r_active[k]),
                .i_y   (w_y),
                .i_cb  (w_cb),
                .i_cr  (w_cr),
                .o_hit (w_hit[k])
            );
        end
    endgenerate

    // Stage 1: hit vector, blanked outside active video.
    always_ff @(posedge pixelclk) begin
        if (reset) begin
            r_hit1 <= '0;
        end else begin
            r_hit1 <= i_de ? w_hit : '0;
        end
    end

    // Priority select: lowest set index wins, none gives the no-class code.
    always_comb begin
        w_class1 = c_no_class;
        for (int k = NUM_CLASS - 1; k >= 0; k--) begin
            if (r_hit1[k]) w_class1 = CLW'(k);
        end
    end

    // Stage 2: registered hit mask and winning class.
    always_ff @(posedge pixelclk) begin
        if (reset) begin
            o_hit   <= '0;
            o_class <= c_no_class;
        end else begin
            o_hit   <= r_hit1;
            o_class <= w_class1;
        end
    end

    // RGB pass-through delay; pure data so it carries no reset.
    always_ff @(posedge pixelclk) begin
        r_rgb1 <= i_rgb;
        o_rgb  <= r_rgb1;
    end

    // Sync and data-enable delay aligned with the classification result.
    always_ff @(posedge pixelclk) begin
        if (reset) begin
            r_hs1   <= 1'b0;
            r_vs1   <= 1'b0;
            r_de1   <= 1'b0;
            o_hsync <= 1'b0;
            o_vsync <= 1'b0;
            o_de    <= 1'b0;
        end else begin
            r_hs1   <= i_hsync;
            r_vs1   <= i_vsync;
            r_de1   <= i_de;
            o_hsync <= r_hs1;
            o_vsync <= r_vs1;
            o_de    <= r_de1;
        end
    end

    assign w_out_frame = o_vsync & ~r_ovs_d;

    // Output-side frame edge detect and the count-valid strobe.
    always_ff @(posedge pixelclk) begin
        if (reset) begin
            r_ovs_d   <= 1'b0;
            o_cnt_vld <= 1'b0;
        end else begin
            r_ovs_d   <= o_vsync;
            o_cnt_vld <= w_out_frame;
        end
    end

`ifdef CLASS_COUNT_EN
    logic [CNTW-1:0] r_cnt [NUM_CLASS];

    // Per-class saturating winner counters; the winner on the edge cycle
    // already belongs to the new frame.
    always_ff @(posedge pixelclk) begin
        if (reset) begin
            o_cnt <= '0;
            for (int k = 0; k < NUM_CLASS; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CLASS; k++) begin
                if (w_out_frame) begin
                    o_cnt[k*CNTW +: CNTW] <= r_cnt[k];
                    r_cnt[k] <= (o_de && (o_class == CLW'(k))) ? CNTW'(1) : '0;
                end else if (o_de && (o_class == CLW'(k)) && (r_cnt[k] != {CNTW{1'b1}})) begin
                    r_cnt[k] <= r_cnt[k] + 1'b1;
                end
            end
        end
    end
`else
    assign o_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ycbcr_class_thresh.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_ycbcr_class_thresh
//  Brief    : Self-checking bench for ycbcr_class_thresh: directed
//             scenarios with literal expectations plus randomized frames
//             compared every cycle against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ycbcr_class_thresh;

    localparam int NC   = 6;
    localparam int CLW  = 3;
    localparam int CNTW = 4;
    localparam int DW   = 24;
    localparam int CMAX = (1 << CNTW) - 1;

    logic                 pixelclk = 1'b0;
    logic                 reset    = 1'b1;
    logic [23:0]          i_ycbcr  = '0;
    logic [DW-1:0]        i_rgb    = '0;
    logic                 i_hsync  = 1'b0;
    logic                 i_vsync  = 1'b0;
    logic                 i_de     = 1'b0;
    logic                 cfg_we   = 1'b0;
    logic [CLW-1:0]       cfg_class = '0;
    logic [48:0]          cfg_wdata = '0;
    logic [CLW-1:0]       o_class;
    logic [NC-1:0]        o_hit;
    logic [DW-1:0]        o_rgb;
    logic                 o_hsync;
    logic                 o_vsync;
    logic                 o_de;
    logic [NC*CNTW-1:0]   o_cnt;
    logic                 o_cnt_vld;

    int checks   = 0;
    int failures = 0;

    always #5 pixelclk = ~pixelclk;

    ycbcr_class_thresh #(
        .CW(8), .DW(DW), .NUM_CLASS(NC), .CLW(CLW), .CNTW(CNTW)
    ) dut (
        .pixelclk (pixelclk),
        .reset    (reset),
        .i_ycbcr  (i_ycbcr),
        .i_rgb    (i_rgb),
        .i_hsync  (i_hsync),
        .i_vsync  (i_vsync),
        .i_de     (i_de),
        .cfg_we   (cfg_we),
        .cfg_class(cfg_class),
        .cfg_wdata(cfg_wdata),
        .o_class  (o_class),
        .o_hit    (o_hit),
        .o_rgb    (o_rgb),
        .o_hsync  (o_hsync),
        .o_vsync  (o_vsync),
        .o_de     (o_de),
        .o_cnt    (o_cnt),
        .o_cnt_vld(o_cnt_vld)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [NC-1:0] hit;
        int            cls;
        logic          de;
        logic          hs;
        logic          vs;
        logic [DW-1:0] rgb;
        bit            rgb_ok;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    exp_t prev;
    bit   have = 0;
    int   sh [NC][7];     // [0]=en, [1..6]=yl,yh,cbl,cbh,crl,crh
    int   ac [NC][7];
    int   cnt  [NC];
    int   ocnt [NC];
    bit   m_vld;
    bit   prev_ov;
    bit   prev_iv;

    always @(posedge pixelclk) begin : model
        exp_t e;
        int   px [3];
        bit   oedge;
        bit   win;
        bit   in_win;
        if (reset) begin
            for (int k = 0; k < NC; k++) begin
                for (int f = 0; f < 7; f++) begin
                    sh[k][f] = 0;
                    ac[k][f] = 0;
                end
                cnt[k]  = 0;
                ocnt[k] = 0;
            end
            m_vld   = 0;
            prev_ov = 0;
            prev_iv = 0;
            e.hit = '0; e.cls = NC; e.de = 0; e.hs = 0; e.vs = 0; e.rgb = '0; e.rgb_ok = 0;
            q.delete();
            q.push_back(e);
            q.push_back(e);
        end else begin
            // frame counting works on what was visible at the outputs
            oedge = prev.vs && !prev_ov;
            for (int k = 0; k < NC; k++) begin
                win = prev.de && (prev.cls == k);
                if (oedge) begin
                    ocnt[k] = cnt[k];
                    cnt[k]  = win ? 1 : 0;
                end else if (win && cnt[k] < CMAX) begin
                    cnt[k]++;
                end
            end
            m_vld   = oedge;
            prev_ov = prev.vs;
            // classify the pixel presented now with the active table
            px[0] = int'(i_ycbcr[23:16]);
            px[1] = int'(i_ycbcr[15:8]);
            px[2] = int'(i_ycbcr[7:0]);
            e.hit = '0;
            e.cls = NC;
            for (int k = 0; k < NC; k++) begin
                in_win = i_de && (ac[k][0] == 1);
                for (int c = 0; c < 3; c++) begin
                    if (px[c] < ac[k][1+2*c] || px[c] > ac[k][2+2*c]) in_win = 0;
                end
                if (in_win) begin
                    e.hit[k] = 1'b1;
                    if (e.cls == NC) e.cls = k;
                end
            end
            e.de = i_de; e.hs = i_hsync; e.vs = i_vsync; e.rgb = i_rgb; e.rgb_ok = 1;
            q.push_back(e);
            // table update: copy first, then the write
            if (i_vsync && !prev_iv) begin
                for (int k = 0; k < NC; k++)
                    for (int f = 0; f < 7; f++) ac[k][f] = sh[k][f];
            end
            if (cfg_we && int'(cfg_class) < NC) begin
                sh[cfg_class][0] = int'(cfg_wdata[48]);
                for (int f = 1; f < 7; f++) sh[cfg_class][f] = int'(cfg_wdata[8*(6-f) +: 8]);
            end
            prev_iv = i_vsync;
        end
        cur  = q.pop_front();
        prev = cur;
        have = 1;
    end

    // Compare outputs against the model every cycle.
    always @(negedge pixelclk) begin : compare
        logic [NC*CNTW-1:0] ecnt;
        if (have) begin
            ecnt = '0;
`ifdef CLASS_COUNT_EN
            for (int k = 0; k < NC; k++) ecnt[k*CNTW +: CNTW] = CNTW'(ocnt[k]);
`endif
            chk("m_hit",   64'(o_hit),    64'(cur.hit));
            chk("m_class", 64'(o_class),  64'(cur.cls));
            chk("m_de",    64'(o_de),     64'(cur.de));
            chk("m_hsync", 64'(o_hsync),  64'(cur.hs));
            chk("m_vsync", 64'(o_vsync),  64'(cur.vs));
            if (cur.rgb_ok) chk("m_rgb", 64'(o_rgb), 64'(cur.rgb));
            chk("m_cnt",   64'(o_cnt),    64'(ecnt));
            chk("m_vld",   64'(o_cnt_vld),64'(m_vld));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge pixelclk);
        #2;
    endtask

    task automatic prog(input int c, input logic en, input logic [7:0] yl, yh, cbl, cbh, crl, crh);
        cfg_we    = 1'b1;
        cfg_class = CLW'(c);
        cfg_wdata = {en, yl, yh, cbl, cbh, crl, crh};
        step();
        cfg_we    = 1'b0;
    endtask

    task automatic vs_pulse();
        i_vsync = 1'b1;
        step();
        step();
        i_vsync = 1'b0;
        step();
    endtask

    task automatic pix_check(input logic [7:0] y, cb, cr, input logic [NC-1:0] eh,
                             input int ec, input string nm);
        i_ycbcr = {y, cb, cr};
        i_rgb   = DW'($urandom);
        i_de    = 1'b1;
        step();
        i_de    = 1'b0;
        step();
        @(negedge pixelclk);
        chk({nm, "_hit"},   64'(o_hit),   64'(eh));
        chk({nm, "_class"}, 64'(o_class), 64'(ec));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bit   seen;
        int   fpos;
        int   flen;
        int   lo;
        int   hi;
        logic [7:0] b [6];

        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        @(negedge pixelclk);
        chk("rst_class", 64'(o_class), 64'(NC));
        chk("rst_hit",   64'(o_hit),   64'd0);
        chk("rst_cnt",   64'(o_cnt),   64'd0);

        // basic classification and priority
        prog(0, 1'b1, 8'd60, 8'd225, 8'd111, 8'd141, 8'd98,  8'd139);
        prog(1, 1'b1, 8'd26, 8'd67,  8'd120, 8'd127, 8'd130, 8'd152);
        vs_pulse();
        pix_check(8'd50,  8'd125, 8'd135, 6'b000010, 1,  "t1");
        pix_check(8'd64,  8'd124, 8'd135, 6'b000011, 0,  "t2_both");
        pix_check(8'd225, 8'd120, 8'd120, 6'b000001, 0,  "t2_y225");
        pix_check(8'd226, 8'd120, 8'd120, 6'b000000, NC, "t2_y226");

        // mid-frame write waits for frame start
        prog(2, 1'b1, 8'd240, 8'd250, 8'd240, 8'd250, 8'd240, 8'd250);
        pix_check(8'd245, 8'd245, 8'd245, 6'b000000, NC, "t3_pending");
        vs_pulse();
        pix_check(8'd245, 8'd245, 8'd245, 6'b000100, 2,  "t3_loaded");
        // write on the frame-start cycle lands one frame later
        i_vsync   = 1'b1;
        cfg_we    = 1'b1;
        cfg_class = CLW'(2);
        cfg_wdata = '0;
        step();
        cfg_we    = 1'b0;
        step();
        i_vsync   = 1'b0;
        step();
        pix_check(8'd245, 8'd245, 8'd245, 6'b000100, 2,  "t3_edge_old");
        vs_pulse();
        pix_check(8'd245, 8'd245, 8'd245, 6'b000000, NC, "t3_edge_new");

        // saturating winner count
        prog(3, 1'b1, 8'd0, 8'd10, 8'd0, 8'd10, 8'd0, 8'd10);
        vs_pulse();
        for (int i = 0; i < 20; i++) begin
            i_ycbcr = {8'd5, 8'd5, 8'd5};
            i_de    = 1'b1;
            step();
        end
        i_de = 1'b0;
        vs_pulse();
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge pixelclk);
            if (o_cnt_vld) seen = 1;
        end
        chk("t4_vld_seen", 64'(seen), 64'd1);
`ifdef CLASS_COUNT_EN
        chk("t4_cnt3", 64'(o_cnt[3*CNTW +: CNTW]), 64'd15);
`else
        chk("t4_cnt3", 64'(o_cnt[3*CNTW +: CNTW]), 64'd0);
`endif
        chk("t4_cnt0", 64'(o_cnt[0 +: CNTW]), 64'd0);
        @(negedge pixelclk);
        chk("t4_vld_pulse", 64'(o_cnt_vld), 64'd0);

        // reset in the middle of a frame
        i_ycbcr = {8'd5, 8'd5, 8'd5};
        i_de    = 1'b1;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        i_de  = 1'b0;
        @(negedge pixelclk);
        chk("t5_class", 64'(o_class), 64'(NC));
        chk("t5_hit",   64'(o_hit),   64'd0);
        chk("t5_de",    64'(o_de),    64'd0);
        chk("t5_cnt",   64'(o_cnt),   64'd0);
        pix_check(8'd5, 8'd5, 8'd5, 6'b000000, NC, "t5_disabled");

        // randomized frames
        fpos = 0;
        flen = 50;
        for (int n = 0; n < 4000; n++) begin
            i_vsync = (fpos < 3);
            i_hsync = ($urandom_range(0, 15) == 0);
            i_de    = !i_vsync && ($urandom_range(0, 9) < 7);
            i_ycbcr = {8'($urandom_range(30, 255)), 8'($urandom_range(30, 255)),
                       8'($urandom_range(30, 255))};
            i_rgb   = DW'($urandom);
            cfg_we  = ($urandom_range(0, 9) == 0);
            cfg_class = CLW'($urandom_range(0, 7));
            for (int c = 0; c < 3; c++) begin
                lo = $urandom_range(40, 160);
                hi = lo + $urandom_range(0, 100);
                if (hi > 255) hi = 255;
                if ($urandom_range(0, 5) == 0) begin
                    b[2*c] = 8'(hi); b[2*c+1] = 8'(lo);
                end else begin
                    b[2*c] = 8'(lo); b[2*c+1] = 8'(hi);
                end
            end
            cfg_wdata = {($urandom_range(0, 4) != 0), b[0], b[1], b[2], b[3], b[4], b[5]};
            reset = ($urandom_range(0, 799) == 0);
            step();
            fpos++;
            if (fpos >= flen) begin
                fpos = 0;
                flen = $urandom_range(30, 90);
            end
        end
        reset  = 1'b0;
        cfg_we = 1'b0;
        i_de   = 1'b0;
        repeat (4) step();
        @(negedge pixelclk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
